// File: rtl/wb_checker_if.sv
// Bus bundle for the writeback checker: expected-queue load, retire stream and status.
// The slave modport is the checker; the master modport is whoever drives it.
interface wb_checker_if #(
    parameter int XLEN  = 64,
    parameter int RA_W  = 5,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) ();
    logic                     start;
    logic                     exp_valid;
    logic                     exp_ready;
    logic [RA_W-1:0]          exp_rd;
    logic [XLEN-1:0]          exp_data;
    logic                     wb_valid;
    logic [RA_W-1:0]          wb_rd;
    logic [XLEN-1:0]          wb_data;
    logic                     busy;
    logic                     done;
    logic                     pass;
    logic                     timeout;
    logic [CNT_W-1:0]         match_cnt;
    logic [CNT_W-1:0]         mismatch_cnt;
    logic [RA_W-1:0]          err_rd;
    logic [XLEN-1:0]          err_exp;
    logic [XLEN-1:0]          err_got;
    logic [$clog2(DEPTH):0]   q_count;

    modport slave (
        input  start, exp_valid, exp_rd, exp_data, wb_valid, wb_rd, wb_data,
        output exp_ready, busy, done, pass, timeout, match_cnt, mismatch_cnt,
               err_rd, err_exp, err_got, q_count
    );

    modport master (
        output start, exp_valid, exp_rd, exp_data, wb_valid, wb_rd, wb_data,
        input  exp_ready, busy, done, pass, timeout, match_cnt, mismatch_cnt,
               err_rd, err_exp, err_got, q_count
    );
endinterface

// File: rtl/wb_checker.sv
// In-order writeback checker: retired register writes are compared against a
// preloaded FIFO of expected (rd, data) pairs, with counters, first-error capture and timeout.
module wb_checker #(
    parameter int XLEN    = 64,
    parameter int RA_W    = 5,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    wb_checker_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int QW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    logic [RA_W-1:0]   r_mem_rd   [DEPTH];
    logic [XLEN-1:0]   r_mem_data [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [QW-1:0]     r_count;
    logic [TW-1:0]     r_timer;
    logic [CNT_W-1:0]  r_match;
    logic [CNT_W-1:0]  r_mismatch;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              r_timeout;
    logic              r_err_seen;
    logic [RA_W-1:0]   r_err_rd;
    logic [XLEN-1:0]   r_err_exp;
    logic [XLEN-1:0]   r_err_got;

    logic              w_ready;
    logic              w_push;
    logic              w_empty;
    logic              w_cmp;
    logic              w_pop;
    logic              w_hit;
    logic              w_err;
    logic [CNT_W-1:0]  w_mm_next;

    assign w_ready = (r_count < QW'(DEPTH));
    assign w_push  = bus.exp_valid && w_ready;
    assign w_empty = (r_count == '0);
    // x0 writes never participate: not compared, not counted, no timer reset
    assign w_cmp   = (r_state == S_RUN) && bus.wb_valid && (bus.wb_rd != '0);
    assign w_pop   = w_cmp && !w_empty;
    assign w_hit   = w_pop && (bus.wb_rd == r_mem_rd[r_rptr])
                           && (bus.wb_data == r_mem_data[r_rptr]);
    assign w_err   = w_cmp && !w_hit;
    assign w_mm_next = (w_err && (r_mismatch != '1)) ? r_mismatch + 1'b1 : r_mismatch;

    // Queue storage has no reset; occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wptr]   <= bus.exp_rd;
            r_mem_data[r_wptr] <= bus.exp_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_timer    <= '0;
            r_match    <= '0;
            r_mismatch <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_err_seen <= 1'b0;
            r_err_rd   <= '0;
            r_err_exp  <= '0;
            r_err_got  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_timer    <= '0;
                        r_match    <= '0;
                        r_mismatch <= '0;
                        r_timeout  <= 1'b0;
                        r_err_seen <= 1'b0;
                        r_err_rd   <= '0;
                        r_err_exp  <= '0;
                        r_err_got  <= '0;
                    end
                end
                S_RUN: begin
                    r_mismatch <= w_mm_next;
                    if (w_hit && (r_match != '1)) r_match <= r_match + 1'b1;
                    if (w_err && !r_err_seen) begin
                        r_err_seen <= 1'b1;
                        r_err_rd   <= bus.wb_rd;
                        r_err_exp  <= w_pop ? r_mem_data[r_rptr] : '0;
                        r_err_got  <= bus.wb_data;
                    end
                    if (w_cmp || w_empty) r_timer <= '0;
                    else                  r_timer <= r_timer + 1'b1;
                    // An empty queue ends the run; a write seen in that same cycle still counts
                    if (w_empty) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_mm_next == '0) && !r_timeout;
                    end else if (!w_cmp && (r_timer == TW'(TIMEOUT - 1))) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.exp_ready    = w_ready;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.pass         = r_pass;
    assign bus.timeout      = r_timeout;
    assign bus.match_cnt    = r_match;
    assign bus.mismatch_cnt = r_mismatch;
    assign bus.err_rd       = r_err_rd;
    assign bus.err_exp      = r_err_exp;
    assign bus.err_got      = r_err_got;
    assign bus.q_count      = r_count;
endmodule

// File: tb/tb_wb_checker.sv
// Directed bench for wb_checker: hand-computed expectations checked with immediate assertions.
module tb_wb_checker;
    localparam int XLEN = 64;
    localparam int RA_W = 5;
    localparam int DEPTH = 8;
    localparam int TIMEOUT = 32;
    localparam int CNT_W = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [63:0] ones;

    wb_checker_if #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    wb_checker #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
        $display("check %-16s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic push(input logic [4:0] rd, input logic [63:0] data);
        bus.exp_valid = 1'b1;
        bus.exp_rd    = rd;
        bus.exp_data  = data;
        tick();
        bus.exp_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [63:0] data);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_data  = data;
        tick();
        bus.wb_valid = 1'b0;
    endtask

    task automatic wb_push(input logic [4:0] rd, input logic [63:0] data,
                           input logic [4:0] prd, input logic [63:0] pdata);
        bus.wb_valid  = 1'b1;
        bus.wb_rd     = rd;
        bus.wb_data   = data;
        bus.exp_valid = 1'b1;
        bus.exp_rd    = prd;
        bus.exp_data  = pdata;
        tick();
        bus.wb_valid  = 1'b0;
        bus.exp_valid = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 100 && !bus.done; i++) tick();
        chk(tag, 64'(bus.done), 64'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ones   = 64'hFFFF_FFFF_FFFF_FFFF;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.exp_valid = 1'b0;
        bus.exp_rd = '0;
        bus.exp_data = '0;
        bus.wb_valid = 1'b0;
        bus.wb_rd = '0;
        bus.wb_data = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Reset state
        chk("rst_busy",   64'(bus.busy), 64'd0);
        chk("rst_done",   64'(bus.done), 64'd0);
        chk("rst_pass",   64'(bus.pass), 64'd0);
        chk("rst_ready",  64'(bus.exp_ready), 64'd1);
        chk("rst_qcount", 64'(bus.q_count), 64'd0);

        // Basic match
        push(5'd4, 64'd11);
        push(5'd3, 64'd12);
        chk("t1_qcount_load", 64'(bus.q_count), 64'd2);
        do_start();
        chk("t1_busy", 64'(bus.busy), 64'd1);
        wb(5'd4, 64'd11);
        chk("t1_match1", 64'(bus.match_cnt), 64'd1);
        chk("t1_q1", 64'(bus.q_count), 64'd1);
        wb(5'd3, 64'd12);
        chk("t1_match2", 64'(bus.match_cnt), 64'd2);
        chk("t1_q0", 64'(bus.q_count), 64'd0);
        chk("t1_done_early", 64'(bus.done), 64'd0);
        tick();
        chk("t1_done", 64'(bus.done), 64'd1);
        chk("t1_pass", 64'(bus.pass), 64'd1);
        chk("t1_busy_off", 64'(bus.busy), 64'd0);
        chk("t1_mismatch", 64'(bus.mismatch_cnt), 64'd0);

        // Mismatch capture
        push(5'd1, ones);
        push(5'd2, 64'd9);
        do_start();
        chk("t2_match_clr", 64'(bus.match_cnt), 64'd0);
        chk("t2_done_clr", 64'(bus.done), 64'd0);
        wb(5'd1, 64'h0000_0000_0000_00FF);
        chk("t2_mm1", 64'(bus.mismatch_cnt), 64'd1);
        wb(5'd2, 64'd9);
        wait_done("t2_done");
        chk("t2_match", 64'(bus.match_cnt), 64'd1);
        chk("t2_mismatch", 64'(bus.mismatch_cnt), 64'd1);
        chk("t2_err_rd", 64'(bus.err_rd), 64'd1);
        chk("t2_err_exp", bus.err_exp, ones);
        chk("t2_err_got", bus.err_got, 64'hFF);
        chk("t2_pass", 64'(bus.pass), 64'd0);

        // x0 and post-done writes
        push(5'd1, 64'd8);
        do_start();
        chk("t3_err_rd_clr", 64'(bus.err_rd), 64'd0);
        chk("t3_err_exp_clr", bus.err_exp, 64'd0);
        wb(5'd0, 64'd5);
        chk("t3_x0_q", 64'(bus.q_count), 64'd1);
        chk("t3_x0_mm", 64'(bus.mismatch_cnt), 64'd0);
        wb(5'd1, 64'd8);
        wait_done("t3_done");
        chk("t3_pass", 64'(bus.pass), 64'd1);
        wb(5'd5, 64'd7);
        tick();
        chk("t3_post_mm", 64'(bus.mismatch_cnt), 64'd0);
        chk("t3_post_match", 64'(bus.match_cnt), 64'd1);
        chk("t3_post_done", 64'(bus.done), 64'd1);

        // Timeout: 32 idle cycles in RUN
        push(5'd2, 64'd9);
        do_start();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("t4_not_yet", 64'(bus.done), 64'd0);
        tick();
        chk("t4_done", 64'(bus.done), 64'd1);
        chk("t4_timeout", 64'(bus.timeout), 64'd1);
        chk("t4_pass", 64'(bus.pass), 64'd0);
        chk("t4_qcount", 64'(bus.q_count), 64'd1);

        // Async reset mid-run, between clock edges
        do_start();
        chk("t6_busy", 64'(bus.busy), 64'd1);
        chk("t6_timeout_clr", 64'(bus.timeout), 64'd0);
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("t6_busy_rst", 64'(bus.busy), 64'd0);
        chk("t6_q_rst", 64'(bus.q_count), 64'd0);
        chk("t6_ready_rst", 64'(bus.exp_ready), 64'd1);
        chk("t6_done_rst", 64'(bus.done), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // Full queue, drop on full, then wrap while retiring
        for (int i = 0; i < 8; i++) push(5'(i + 1), 64'(100 + 3 * i));
        chk("t5_q8", 64'(bus.q_count), 64'd8);
        chk("t5_ready0", 64'(bus.exp_ready), 64'd0);
        push(5'd30, 64'hDEAD);
        chk("t5_drop_q", 64'(bus.q_count), 64'd8);
        do_start();
        wb(5'd1, 64'd100);
        chk("t5_q7", 64'(bus.q_count), 64'd7);
        for (int k = 1; k < 4; k++) begin
            wb_push(5'(k + 1), 64'(100 + 3 * k), 5'(10 + k), 64'(4096 + k));
            chk("t5_q_hold", 64'(bus.q_count), 64'd7);
        end
        for (int k = 4; k < 8; k++) begin
            wb(5'(k + 1), 64'(100 + 3 * k));
            chk("t5_q_drain", 64'(bus.q_count), 64'(10 - k));
        end
        for (int k = 1; k < 4; k++) wb(5'(10 + k), 64'(4096 + k));
        chk("t5_q_empty", 64'(bus.q_count), 64'd0);
        wait_done("t5_done");
        chk("t5_match", 64'(bus.match_cnt), 64'd11);
        chk("t5_mismatch", 64'(bus.mismatch_cnt), 64'd0);
        chk("t5_pass", 64'(bus.pass), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
